// File: rtl/mat_pkg.sv
// Shared types and constants for the 4-lane sparse-matrix stream.
//   LANES   : lanes per beat
//   cplx_t  : complex value, 32-bit real and imaginary parts
//   col_w() : column/row index width for a given matrix rank
//   pack_state_t : pack-register states of the row packer
package mat_pkg;

  localparam int LANES = 4;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_HELD    = 2'd2
  } pack_state_t;

  function automatic int col_w(input int rank);
    return $clog2(rank);
  endfunction

endpackage

// File: rtl/mat_beat_reg.sv
// Single-entry holding register with valid/ready handshake.
//   i_load  : capture i_data (caller only loads when o_free is high)
//   i_data  : beat payload
//   o_vld   : payload valid
//   o_data  : held payload, stable while o_vld is high and i_rdy is low
//   i_rdy   : sink ready
//   o_free  : register is empty or drains this cycle
module mat_beat_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  output logic         o_vld,
  output logic [W-1:0] o_data,
  input  logic         i_rdy,
  output logic         o_free
);

  logic         r_vld;
  logic [W-1:0] r_data;

  assign o_vld  = r_vld;
  assign o_data = r_data;
  assign o_free = !r_vld || i_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_vld  <= 1'b1;
      r_data <= i_data;
    end else if (i_rdy) begin
      r_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/sparse_row_packer.sv
// Packs single complex nonzero entries into 4-lane beats closed at 4 lanes,
// row end or matrix end, with row bookkeeping on the output stream.
//   E_*        : entry input (valid/ready), one entry per cycle
//   Scol_index : lane k column at [k*COL_W +: COL_W]
//   S_val_r/i* : lane real/imaginary parts
//   S_mask_o, S_row_o, S_row_last_o, S_mat_last_o : beat bookkeeping
//   S_vld_o / S_rdy_i : output handshake
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_EMPTY   | pack register empty (count 0)
// ST_FILLING | count 1..3 lanes packed, beat still open
// ST_HELD    | closed beat waiting for the output register to free up
module sparse_row_packer
  import mat_pkg::*;
#(
  parameter int  MAT_RANK = 256,
  localparam int COL_W    = col_w(MAT_RANK)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               E_vld_i,
  output logic               E_rdy_o,
  input  logic               E_nz_i,
  input  logic [COL_W-1:0]   E_col_i,
  input  logic [31:0]        E_val_r_i,
  input  logic [31:0]        E_val_i_i,
  input  logic               E_row_last_i,
  input  logic               E_mat_last_i,
  output logic [4*COL_W-1:0] Scol_index,
  output logic [31:0]        S_val_r0,
  output logic [31:0]        S_val_r1,
  output logic [31:0]        S_val_r2,
  output logic [31:0]        S_val_r3,
  output logic [31:0]        S_val_i0,
  output logic [31:0]        S_val_i1,
  output logic [31:0]        S_val_i2,
  output logic [31:0]        S_val_i3,
  output logic [3:0]         S_mask_o,
  output logic [COL_W-1:0]   S_row_o,
  output logic               S_row_last_o,
  output logic               S_mat_last_o,
  output logic               S_vld_o,
  input  logic               S_rdy_i
);

  localparam int CPLX_W = $bits(cplx_t);
  localparam int CW_TOT = LANES * COL_W;
  localparam int VW_TOT = LANES * CPLX_W;
  localparam int BEAT_W = CW_TOT + VW_TOT + LANES + 2;

  pack_state_t      r_state, w_state_nxt;
  logic [1:0]       r_cnt;
  logic [COL_W-1:0] r_col [LANES];
  cplx_t            r_val [LANES];
  logic [LANES-1:0] r_hmask;
  logic             r_hrow_last, r_hmat_last;
  logic [COL_W-1:0] r_row;

  logic             w_acc, w_close, w_free, w_load, w_xfer;
  logic [COL_W-1:0] w_col [LANES];
  cplx_t            w_val [LANES];
  logic [LANES-1:0] w_mask;
  logic             w_row_last, w_mat_last;
  logic [CW_TOT-1:0] w_cols_flat;
  logic [VW_TOT-1:0] w_vals_flat;
  logic [BEAT_W-1:0] w_beat, w_out;
  logic [VW_TOT-1:0] w_out_vals;

  assign w_acc   = E_vld_i && E_rdy_o;
  assign w_close = w_acc && ((r_cnt == 2'd3) || E_row_last_i || E_mat_last_i);
  assign w_xfer  = S_vld_o && S_rdy_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HELD: if (w_free) w_state_nxt = ST_EMPTY;
      default: begin
        if (w_close)                w_state_nxt = w_free ? ST_EMPTY : ST_HELD;
        else if (w_acc && E_nz_i)   w_state_nxt = ST_FILLING;
      end
    endcase
  end

  always_comb begin
    E_rdy_o = (r_state != ST_HELD);
    w_load  = (r_state == ST_HELD) ? w_free : (w_close && w_free);
  end

  // Beat as it would leave the pack register this cycle: the stored beat
  // while held, otherwise the packed lanes plus the current entry.
  always_comb begin
    w_col      = r_col;
    w_val      = r_val;
    for (int k = 0; k < LANES; k++) w_mask[k] = (k < int'(r_cnt));
    w_row_last = E_row_last_i || E_mat_last_i;
    w_mat_last = E_mat_last_i;
    if (r_state == ST_HELD) begin
      w_mask     = r_hmask;
      w_row_last = r_hrow_last;
      w_mat_last = r_hmat_last;
    end else if (E_nz_i) begin
      w_col[r_cnt]  = E_col_i;
      w_val[r_cnt]  = {E_val_r_i, E_val_i_i};
      w_mask[r_cnt] = 1'b1;
    end
  end

  // Stale lanes from earlier beats are zeroed here, so padding is always 0.
  always_comb begin
    w_cols_flat = '0;
    w_vals_flat = '0;
    for (int k = 0; k < LANES; k++) begin
      if (w_mask[k]) begin
        w_cols_flat[k*COL_W +: COL_W]   = w_col[k];
        w_vals_flat[k*CPLX_W +: CPLX_W] = w_val[k];
      end
    end
  end

  assign w_beat = {w_mat_last, w_row_last, w_mask, w_vals_flat, w_cols_flat};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_hmask     <= '0;
      r_hrow_last <= 1'b0;
      r_hmat_last <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        r_col[k] <= '0;
        r_val[k] <= '0;
      end
    end else if (r_state != ST_HELD) begin
      if (w_close) begin
        r_cnt <= '0;
        if (!w_free) begin
          r_col       <= w_col;
          r_val       <= w_val;
          r_hmask     <= w_mask;
          r_hrow_last <= w_row_last;
          r_hmat_last <= w_mat_last;
        end
      end else if (w_acc && E_nz_i) begin
        r_col[r_cnt] <= E_col_i;
        r_val[r_cnt] <= {E_val_r_i, E_val_i_i};
        r_cnt        <= r_cnt + 2'd1;
      end
    end
  end

  // Beats leave in order, so the counter always names the row of the beat
  // currently in the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
    end else if (w_xfer) begin
      if (S_mat_last_o)      r_row <= '0;
      else if (S_row_last_o) r_row <= r_row + COL_W'(1);
    end
  end

  mat_beat_reg #(.W(BEAT_W)) u_out (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_data (w_beat),
    .o_vld  (S_vld_o),
    .o_data (w_out),
    .i_rdy  (S_rdy_i),
    .o_free (w_free)
  );

  assign Scol_index   = w_out[CW_TOT-1:0];
  assign w_out_vals   = w_out[CW_TOT +: VW_TOT];
  assign S_val_r0     = w_out_vals[0*CPLX_W + 32 +: 32];
  assign S_val_i0     = w_out_vals[0*CPLX_W +: 32];
  assign S_val_r1     = w_out_vals[1*CPLX_W + 32 +: 32];
  assign S_val_i1     = w_out_vals[1*CPLX_W +: 32];
  assign S_val_r2     = w_out_vals[2*CPLX_W + 32 +: 32];
  assign S_val_i2     = w_out_vals[2*CPLX_W +: 32];
  assign S_val_r3     = w_out_vals[3*CPLX_W + 32 +: 32];
  assign S_val_i3     = w_out_vals[3*CPLX_W +: 32];
  assign S_mask_o     = w_out[CW_TOT + VW_TOT +: LANES];
  assign S_row_last_o = w_out[BEAT_W-2];
  assign S_mat_last_o = w_out[BEAT_W-1];
  assign S_row_o      = r_row;

endmodule

// File: tb/tb_sparse_row_packer.sv
// Directed bench for sparse_row_packer (MAT_RANK = 256, COL_W = 8).
module tb_sparse_row_packer;

  localparam int COL_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             E_vld_i, E_rdy_o, E_nz_i, E_row_last_i, E_mat_last_i;
  logic [COL_W-1:0] E_col_i;
  logic [31:0]      E_val_r_i, E_val_i_i;
  logic [4*COL_W-1:0] Scol_index;
  logic [31:0]      S_val_r0, S_val_r1, S_val_r2, S_val_r3;
  logic [31:0]      S_val_i0, S_val_i1, S_val_i2, S_val_i3;
  logic [3:0]       S_mask_o;
  logic [COL_W-1:0] S_row_o;
  logic             S_row_last_o, S_mat_last_o, S_vld_o, S_rdy_i;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0]       mask;
    logic [31:0]      col;
    logic [3:0][31:0] re;
    logic [3:0][31:0] im;
    logic [7:0]       row;
    logic             rl;
    logic             ml;
  } beat_t;

  beat_t q[$];

  always #5 clk = ~clk;

  sparse_row_packer #(.MAT_RANK(256)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .E_vld_i      (E_vld_i),
    .E_rdy_o      (E_rdy_o),
    .E_nz_i       (E_nz_i),
    .E_col_i      (E_col_i),
    .E_val_r_i    (E_val_r_i),
    .E_val_i_i    (E_val_i_i),
    .E_row_last_i (E_row_last_i),
    .E_mat_last_i (E_mat_last_i),
    .Scol_index   (Scol_index),
    .S_val_r0     (S_val_r0),
    .S_val_r1     (S_val_r1),
    .S_val_r2     (S_val_r2),
    .S_val_r3     (S_val_r3),
    .S_val_i0     (S_val_i0),
    .S_val_i1     (S_val_i1),
    .S_val_i2     (S_val_i2),
    .S_val_i3     (S_val_i3),
    .S_mask_o     (S_mask_o),
    .S_row_o      (S_row_o),
    .S_row_last_o (S_row_last_o),
    .S_mat_last_o (S_mat_last_o),
    .S_vld_o      (S_vld_o),
    .S_rdy_i      (S_rdy_i)
  );

  // Record every output transfer (inputs only change #1 after posedge).
  always @(negedge clk) begin
    if (rst_n && S_vld_o && S_rdy_i) begin
      beat_t b;
      b.mask = S_mask_o;
      b.col  = Scol_index;
      b.re   = {S_val_r3, S_val_r2, S_val_r1, S_val_r0};
      b.im   = {S_val_i3, S_val_i2, S_val_i1, S_val_i0};
      b.row  = S_row_o;
      b.rl   = S_row_last_o;
      b.ml   = S_mat_last_o;
      q.push_back(b);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic nz, input int col, input logic rl, input logic ml);
    E_vld_i      = 1'b1;
    E_nz_i       = nz;
    E_col_i      = col[7:0];
    E_val_r_i    = nz ? (32'hA000_0000 | 32'(col)) : 32'hDEAD_BEEF;
    E_val_i_i    = nz ? (32'hB000_0000 | 32'(col)) : 32'hFEED_F00D;
    E_row_last_i = rl;
    E_mat_last_i = ml;
  endtask

  task automatic offer(input logic nz, input int col, input logic rl, input logic ml);
    logic acc;
    acc = 1'b0;
    drive(nz, col, rl, ml);
    for (int i = 0; i < 20; i++) begin
      if (E_rdy_o) begin
        step();
        acc = 1'b1;
        break;
      end
      step();
    end
    E_vld_i = 1'b0;
    chk($sformatf("offer_accept_col%0d", col), acc, 1'b1);
  endtask

  task automatic check_beat(input string tag, input logic [3:0] m,
                            input int c0, input int c1, input int c2, input int c3,
                            input int row, input logic rl, input logic ml);
    beat_t       b;
    int          cols[4];
    logic [31:0] ecol;
    chk({tag, "_present"}, (q.size() != 0), 1'b1);
    if (q.size() == 0) return;
    b = q.pop_front();
    cols[0] = c0; cols[1] = c1; cols[2] = c2; cols[3] = c3;
    ecol = '0;
    for (int k = 0; k < 4; k++) if (m[k]) ecol[k*8 +: 8] = cols[k][7:0];
    chk({tag, "_mask"}, b.mask, m);
    chk({tag, "_col"}, b.col, ecol);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_re%0d", tag, k), b.re[k], m[k] ? (32'hA000_0000 | 32'(cols[k])) : 32'h0);
      chk($sformatf("%s_im%0d", tag, k), b.im[k], m[k] ? (32'hB000_0000 | 32'(cols[k])) : 32'h0);
    end
    chk({tag, "_row"}, b.row, row);
    chk({tag, "_row_last"}, b.rl, rl);
    chk({tag, "_mat_last"}, b.ml, ml);
  endtask

  initial begin
    int          idx;
    logic        acc;
    logic [31:0] snap_col, snap_re3;
    logic [3:0]  snap_mask;

    E_vld_i = 1'b0; E_nz_i = 1'b0; E_col_i = '0; E_val_r_i = '0; E_val_i_i = '0;
    E_row_last_i = 1'b0; E_mat_last_i = 1'b0; S_rdy_i = 1'b1;

    // Reset state
    #12;
    chk("rst_vld", S_vld_o, 1'b0);
    chk("rst_mask", S_mask_o, 4'h0);
    chk("rst_col", Scol_index, 32'h0);
    chk("rst_val", S_val_r0, 32'h0);
    chk("rst_row", S_row_o, 8'd0);
    chk("rst_flags", {S_row_last_o, S_mat_last_o}, 2'b00);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_erdy", E_rdy_o, 1'b1);

    // Full 4-lane row, latency 1 from closing acceptance
    offer(1, 3, 0, 0);
    offer(1, 7, 0, 0);
    offer(1, 9, 0, 0);
    offer(1, 200, 1, 0);
    chk("t1_latency_vld", S_vld_o, 1'b1);
    chk("t1_row_out", S_row_o, 8'd0);
    step(); step();
    check_beat("t1", 4'hF, 3, 7, 9, 200, 0, 1, 0);
    chk("t1_row_next", S_row_o, 8'd1);

    // Row of 6 then row of 2 closed by mat_last alone
    for (int i = 1; i <= 6; i++) offer(1, i, (i == 6), 0);
    offer(1, 10, 0, 0);
    offer(1, 11, 0, 1);
    repeat (3) step();
    check_beat("t2a", 4'hF, 1, 2, 3, 4, 1, 0, 0);
    check_beat("t2b", 4'h3, 5, 6, 0, 0, 1, 1, 0);
    check_beat("t2c", 4'h3, 10, 11, 0, 0, 2, 1, 1);
    chk("t2_row_wrap", S_row_o, 8'd0);

    // Empty row, zero-flag entry closing a partial beat, single-entry matrix end
    offer(0, 77, 1, 0);
    offer(1, 5, 0, 0);
    offer(0, 77, 1, 0);
    offer(1, 8, 0, 1);
    repeat (3) step();
    check_beat("t3a", 4'h0, 0, 0, 0, 0, 0, 1, 0);
    check_beat("t3b", 4'h1, 5, 0, 0, 0, 1, 1, 0);
    check_beat("t3c", 4'h1, 8, 0, 0, 0, 2, 1, 1);
    chk("t3_row_wrap", S_row_o, 8'd0);

    // 10 entries back-to-back, sink stalled for edges 4..8
    idx = 0;
    snap_col = '0; snap_re3 = '0; snap_mask = '0;
    for (int c = 0; c < 13; c++) begin
      S_rdy_i = (c >= 3 && c < 8) ? 1'b0 : 1'b1;
      chk($sformatf("t4_erdy_c%0d", c), E_rdy_o, (c == 8) ? 1'b0 : 1'b1);
      chk($sformatf("t4_svld_c%0d", c), S_vld_o, ((c >= 4 && c <= 9) || c == 11));
      if (c == 4) begin
        snap_col = Scol_index; snap_re3 = S_val_r3; snap_mask = S_mask_o;
      end
      if (c >= 5 && c <= 8) begin
        chk($sformatf("t4_stable_col_c%0d", c), Scol_index, snap_col);
        chk($sformatf("t4_stable_re3_c%0d", c), S_val_r3, snap_re3);
        chk($sformatf("t4_stable_mask_c%0d", c), S_mask_o, snap_mask);
      end
      if (c == 9) chk("t4_nobubble_col", Scol_index, {8'd27, 8'd26, 8'd25, 8'd24});
      if (idx < 10) drive(1, 20 + idx, (idx == 9), 0);
      else          E_vld_i = 1'b0;
      acc = E_vld_i && E_rdy_o;
      step();
      if (acc) idx++;
    end
    E_vld_i = 1'b0;
    chk("t4_snap_col", snap_col, {8'd23, 8'd22, 8'd21, 8'd20});
    chk("t4_accepted", idx, 32'd10);
    check_beat("t4a", 4'hF, 20, 21, 22, 23, 0, 0, 0);
    check_beat("t4b", 4'hF, 24, 25, 26, 27, 0, 0, 0);
    check_beat("t4c", 4'h3, 28, 29, 0, 0, 0, 1, 0);
    chk("t4_row_next", S_row_o, 8'd1);

    // Closing entry accepted while the output drains
    S_rdy_i = 1'b1;
    offer(1, 40, 1, 0);
    chk("t5_vld1", S_vld_o, 1'b1);
    chk("t5_erdy1", E_rdy_o, 1'b1);
    offer(1, 41, 1, 0);
    chk("t5_vld2", S_vld_o, 1'b1);
    chk("t5_erdy2", E_rdy_o, 1'b1);
    chk("t5_col2", Scol_index[7:0], 8'd41);
    chk("t5_row2", S_row_o, 8'd2);
    repeat (2) step();
    check_beat("t5a", 4'h1, 40, 0, 0, 0, 1, 1, 0);
    check_beat("t5b", 4'h1, 41, 0, 0, 0, 2, 1, 0);

    // Async reset with a pending beat and two packed lanes
    S_rdy_i = 1'b0;
    offer(1, 50, 1, 0);
    offer(1, 51, 0, 0);
    offer(1, 52, 0, 0);
    chk("t6_pending", S_vld_o, 1'b1);
    chk("t6_row_before", S_row_o, 8'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", S_vld_o, 1'b0);
    chk("t6_rst_mask", S_mask_o, 4'h0);
    chk("t6_rst_col", Scol_index, 32'h0);
    chk("t6_rst_row", S_row_o, 8'd0);
    step();
    rst_n = 1'b1;
    S_rdy_i = 1'b1;
    step();
    offer(1, 60, 1, 0);
    chk("t6_row_after", S_row_o, 8'd0);
    repeat (2) step();
    check_beat("t6", 4'h1, 60, 0, 0, 0, 0, 1, 0);
    chk("q_empty", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
